shared_adder_arbiter: RTL and testbench
=======================================

// Module: shared_adder_arbiter
// PURPOSE
//  Shares one WIDTH-bit add/subtract datapath among NUM_REQ requesters in the multicycle core
//  (e.g. PC+4, branch target, load/store address).
//  Captures single-cycle request pulses into pending bits and arbitrates among them.
//  Latches the winner's operands, performs one registered add/sub and returns a tagged result.
// PARAMETERS
//  WIDTH    32  operand/result width in bits
//  NUM_REQ  3   number of requesters (>=2)
//  ID_W     $clog2(NUM_REQ)  requester index width (derived, localparam)
// PORTS
//  i_clk     in   1              core clock; all state on rising edge
//  i_rst_n   in   1              asynchronous, active-low reset
//  i_req     in   NUM_REQ        one-cycle request pulse per requester
//  i_sub     in   NUM_REQ        per-requester op select: 0 = a+b, 1 = a-b; sampled at grant
//  i_op_a    in   NUM_REQ*WIDTH  flattened operand A; slice i = [i*WIDTH +: WIDTH]
//  i_op_b    in   NUM_REQ*WIDTH  flattened operand B, same packing
//  o_gnt     out  NUM_REQ        one-hot grant, one cycle; operands have been captured
//  o_valid   out  NUM_REQ        one-hot result-valid pulse, one cycle
//  o_result  out  WIDTH          last result; held until next completion
//  o_id      out  ID_W           index of requester owning o_result
//  o_busy    out  1              1 while state != S_IDLE or any pending bit set
// BEHAVIOUR
//  Reset (async assert, sync release): state=S_IDLE; pend=0; rr_ptr=0; op regs=0;
//    o_gnt=0, o_valid=0, o_result=0, o_id=0, o_busy=0.
//  All outputs registered except o_busy, which is combinational from state/pend.
//  Pending: i_req[i] sets pend[i]; the grant of i clears it.
//    A new pulse on i_req[i] while pend[i]=1 is absorbed (no double count).
//    If i_req[i] rises on the same edge as grant of i, pend[i] stays 1 (the new request wins).
//  Requester holds i_op_a/i_op_b/i_sub slice stable from its req pulse until it sees o_gnt.
//  FSM:
//    S_IDLE: if pend!=0 -> pick winner w, capture operands(w), i_sub[w], id=w;
//            o_gnt<=onehot(w); clear pend[w] -> S_ADD. Else stay.
//    S_ADD:  o_result <= a + (sub ? ~b : b) + sub (mod 2^WIDTH); o_id <= id;
//            o_valid <= onehot(id) -> S_IDLE.
//  A request pending at edge E gets o_gnt in cycle E+1 and o_valid in cycle E+2.
//  Back-to-back throughput: one operation per 2 cycles; arbitration resumes in the cycle o_valid is high.
//  A request pulse arriving in the same cycle as the arbitration is not eligible until the next S_IDLE edge.
//  Overflow/carry discarded; wrap-around modulo 2^WIDTH.
//  Reset mid-operation: in-flight op and all pending requests are dropped; no o_valid is produced.
// CONFIGURATION
//  SHARED_ADDER_RR_EN defined: round-robin.
//    Search starts at rr_ptr; after a grant to w, rr_ptr <= (w+1) mod NUM_REQ.
//  SHARED_ADDER_RR_EN undefined: fixed priority, lowest index wins; rr_ptr logic removed.
// STRUCTURE
//  Package shared_adder_pkg: state encoding (S_IDLE=1'b0, S_ADD=1'b1), default WIDTH/NUM_REQ, ID_W function.
//  Sub-module rr_pick: combinational pend/rr_ptr -> one-hot winner + index.
//    Implemented as a masked + unmasked priority encoder; in fixed-priority mode it reduces to the unmasked encoder.
//  Datapath: single adder with operand-B inversion.
// TESTING
//  1. Single req0: a=0x0000_0005, b=0x0000_0003, add
//       -> o_gnt=001 next cycle; o_valid=001, o_result=0x8, o_id=0 one cycle later.
//  2. Sub wrap: req1 sub, a=0x0, b=0x1
//       -> o_result=0xFFFF_FFFF; req2 add, a=0xFFFF_FFFF, b=0x2 -> o_result=0x1.
//  3. Simultaneous req=111 (RR_EN)
//       -> grants 001, 010, 100 on cycles 1, 3, 5; valids follow by one cycle.
//     Without macro, repeated pulses on req0 every 2 cycles starve req1.
//  4. req0 re-pulsed on its own grant edge -> pend[0] stays set; second o_gnt=001 two cycles later.
//  5. req0 pulsed twice while pend[0]=1 -> exactly one grant and one o_valid.
//  6. i_rst_n low during S_ADD -> o_valid never pulses; all outputs 0.
//     After release with no req, o_busy=0.

Source files
------------

// File: rtl/shared_adder_pkg.sv
// Shared types and helpers for the shared add/sub arbiter.
// Holds the FSM encoding, default sizing and the requester-index width function.
package shared_adder_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_NUM_REQ = 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ADD  = 1'b1
    } state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int calc_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_adder_arbiter_if.sv
// Request/result bundle between the requesters (master) and the shared adder (slave).
interface shared_adder_arbiter_if
    import shared_adder_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ
);
    localparam int ID_W = calc_id_w(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       sub;
    logic [NUM_REQ*WIDTH-1:0] op_a;
    logic [NUM_REQ*WIDTH-1:0] op_b;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       valid;
    logic [WIDTH-1:0]         result;
    logic [ID_W-1:0]          id;
    logic                     busy;

    modport master (
        output req, sub, op_a, op_b,
        input  gnt, valid, result, id, busy
    );

    modport slave (
        input  req, sub, op_a, op_b,
        output gnt, valid, result, id, busy
    );

endinterface

// File: rtl/shared_adder_arbiter_rr_pick.sv
// Winner selection over the pending vector. With SHARED_ADDER_RR_EN the search starts
// at rr_ptr (masked encoder, falling back to unmasked); otherwise lowest index wins.
module shared_adder_arbiter_rr_pick
    import shared_adder_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = calc_id_w(NUM_REQ)
)
(
    input  logic [NUM_REQ-1:0] pend,
`ifdef SHARED_ADDER_RR_EN
    input  logic [ID_W-1:0]    rr_ptr,
`endif
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [ID_W-1:0]    win_idx,
    output logic               win_valid
);

    logic [NUM_REQ-1:0] sel_s;
`ifdef SHARED_ADDER_RR_EN
    logic [NUM_REQ-1:0] mask_s;
    logic [NUM_REQ-1:0] masked_s;
`endif

    function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_REQ-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = {ID_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Choose the candidate vector, then encode the lowest set bit.
    always_comb begin
`ifdef SHARED_ADDER_RR_EN
        mask_s = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            mask_s[i] = (ID_W'(i) >= rr_ptr);
        end
        masked_s = pend & mask_s;
        if (masked_s != {NUM_REQ{1'b0}}) begin
            sel_s = masked_s;
        end else begin
            sel_s = pend;
        end
`else
        sel_s = pend;
`endif
        win_valid = |pend;
        win_idx   = lowest_idx(sel_s);
        if (win_valid) begin
            win_onehot = NUM_REQ'(1'b1) << win_idx;
        end else begin
            win_onehot = {NUM_REQ{1'b0}};
        end
    end

endmodule

// File: rtl/shared_adder_arbiter.sv
// One WIDTH-bit add/sub datapath shared by NUM_REQ requesters: pulses are latched as
// pending bits, one winner per two cycles. Build option: SHARED_ADDER_RR_EN (round-robin).
module shared_adder_arbiter
    import shared_adder_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ
)
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    shared_adder_arbiter_if.slave bus
);

    localparam int ID_W = calc_id_w(NUM_REQ);

    state_t             state_r;
    logic [NUM_REQ-1:0] pend_r;
    logic [WIDTH-1:0]   op_a_r;
    logic [WIDTH-1:0]   op_b_r;
    logic               sub_r;
    logic [ID_W-1:0]    id_r;
    logic [NUM_REQ-1:0] gnt_r;
    logic [NUM_REQ-1:0] valid_r;
    logic [WIDTH-1:0]   result_r;
    logic [ID_W-1:0]    out_id_r;
`ifdef SHARED_ADDER_RR_EN
    logic [ID_W-1:0]    rr_ptr_r;
`endif

    logic [NUM_REQ-1:0] win_onehot_s;
    logic [ID_W-1:0]    win_idx_s;
    logic               win_valid_s;
    logic [NUM_REQ-1:0] clr_s;
    logic [WIDTH-1:0]   sum_s;
    logic               busy_s;

    shared_adder_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .pend       (pend_r),
`ifdef SHARED_ADDER_RR_EN
        .rr_ptr     (rr_ptr_r),
`endif
        .win_onehot (win_onehot_s),
        .win_idx    (win_idx_s),
        .win_valid  (win_valid_s)
    );

    // Pending clear mask, adder with operand-B inversion, and busy flag.
    always_comb begin
        if (state_r == S_IDLE) begin
            clr_s = win_onehot_s;
        end else begin
            clr_s = {NUM_REQ{1'b0}};
        end
        sum_s  = op_a_r + (sub_r ? ~op_b_r : op_b_r) + {{(WIDTH-1){1'b0}}, sub_r};
        busy_s = (state_r != S_IDLE) || (pend_r != {NUM_REQ{1'b0}});
    end

    // Arbitration FSM, request capture and registered result outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= S_IDLE;
            pend_r   <= {NUM_REQ{1'b0}};
            op_a_r   <= {WIDTH{1'b0}};
            op_b_r   <= {WIDTH{1'b0}};
            sub_r    <= 1'b0;
            id_r     <= {ID_W{1'b0}};
            gnt_r    <= {NUM_REQ{1'b0}};
            valid_r  <= {NUM_REQ{1'b0}};
            result_r <= {WIDTH{1'b0}};
            out_id_r <= {ID_W{1'b0}};
`ifdef SHARED_ADDER_RR_EN
            rr_ptr_r <= {ID_W{1'b0}};
`endif
        end else begin
            gnt_r   <= {NUM_REQ{1'b0}};
            valid_r <= {NUM_REQ{1'b0}};
            // A pulse landing on its own grant edge re-arms the pending bit.
            pend_r  <= (pend_r & ~clr_s) | bus.req;
            case (state_r)
                S_IDLE: begin
                    if (win_valid_s) begin
                        op_a_r  <= bus.op_a[win_idx_s*WIDTH +: WIDTH];
                        op_b_r  <= bus.op_b[win_idx_s*WIDTH +: WIDTH];
                        sub_r   <= bus.sub[win_idx_s];
                        id_r    <= win_idx_s;
                        gnt_r   <= win_onehot_s;
                        state_r <= S_ADD;
`ifdef SHARED_ADDER_RR_EN
                        if (win_idx_s == ID_W'(NUM_REQ - 1)) begin
                            rr_ptr_r <= {ID_W{1'b0}};
                        end else begin
                            rr_ptr_r <= win_idx_s + ID_W'(1'b1);
                        end
`endif
                    end
                end
                S_ADD: begin
                    result_r <= sum_s;
                    out_id_r <= id_r;
                    valid_r  <= NUM_REQ'(1'b1) << id_r;
                    state_r  <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_r;
    assign bus.valid  = valid_r;
    assign bus.result = result_r;
    assign bus.id     = out_id_r;
    assign bus.busy   = busy_s;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed bench for shared_adder_arbiter; expectations follow SHARED_ADDER_RR_EN when defined.
module tb_shared_adder_arbiter;
    import shared_adder_pkg::*;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 3;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    shared_adder_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus();

    shared_adder_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_op(input int r, input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.op_a[r*WIDTH +: WIDTH] = a;
        bus.op_b[r*WIDTH +: WIDTH] = b;
        bus.sub[r] = s;
    endtask

    task automatic pulse(input logic [2:0] r);
        bus.req = r;
        tick();
        bus.req = 3'b000;
    endtask

    task automatic apply_reset();
        bus.req = 3'b000;
        i_rst_n = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus.req = 3'b000;
        i_rst_n = 1'b0;
        tick();
        tick();
        tests_run++; if (bus.gnt !== 3'b000) begin tests_failed++; $display("FAIL reset_gnt: got %b want 000", bus.gnt); end
        tests_run++; if (bus.valid !== 3'b000) begin tests_failed++; $display("FAIL reset_valid: got %b want 000", bus.valid); end
        tests_run++; if (bus.result !== 32'h0) begin tests_failed++; $display("FAIL reset_result: got %h want 0", bus.result); end
        tests_run++; if (bus.id !== 2'd0) begin tests_failed++; $display("FAIL reset_id: got %0d want 0", bus.id); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_op(0, 1'b0, 32'h0000_0005, 32'h0000_0003);
        pulse(3'b001);
        tests_run++; if (bus.gnt !== 3'b000) begin tests_failed++; $display("FAIL single_gnt_early: got %b want 000", bus.gnt); end
        tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %b want 1", bus.busy); end
        tick();
        tests_run++; if (bus.gnt !== 3'b001) begin tests_failed++; $display("FAIL single_gnt: got %b want 001", bus.gnt); end
        tick();
        tests_run++; if (bus.valid !== 3'b001) begin tests_failed++; $display("FAIL single_valid: got %b want 001", bus.valid); end
        tests_run++; if (bus.result !== 32'h0000_0008) begin tests_failed++; $display("FAIL single_result: got %h want 00000008", bus.result); end
        tests_run++; if (bus.id !== 2'd0) begin tests_failed++; $display("FAIL single_id: got %0d want 0", bus.id); end
        tests_run++; if (bus.gnt !== 3'b000) begin tests_failed++; $display("FAIL single_gnt_pulse: got %b want 000", bus.gnt); end
        tick();
        tests_run++; if (bus.valid !== 3'b000) begin tests_failed++; $display("FAIL single_valid_pulse: got %b want 000", bus.valid); end
        tests_run++; if (bus.result !== 32'h0000_0008) begin tests_failed++; $display("FAIL single_result_hold: got %h want 00000008", bus.result); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle: got %b want 0", bus.busy); end
    endtask

    task automatic test_sub_wrap();
        set_op(1, 1'b1, 32'h0000_0000, 32'h0000_0001);
        pulse(3'b010);
        tick();
        tests_run++; if (bus.gnt !== 3'b010) begin tests_failed++; $display("FAIL wrap_gnt1: got %b want 010", bus.gnt); end
        tick();
        tests_run++; if (bus.valid !== 3'b010) begin tests_failed++; $display("FAIL wrap_valid1: got %b want 010", bus.valid); end
        tests_run++; if (bus.result !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL wrap_sub: got %h want ffffffff", bus.result); end
        tests_run++; if (bus.id !== 2'd1) begin tests_failed++; $display("FAIL wrap_id1: got %0d want 1", bus.id); end
        set_op(2, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002);
        pulse(3'b100);
        tick();
        tests_run++; if (bus.gnt !== 3'b100) begin tests_failed++; $display("FAIL wrap_gnt2: got %b want 100", bus.gnt); end
        tick();
        tests_run++; if (bus.result !== 32'h0000_0001) begin tests_failed++; $display("FAIL wrap_add: got %h want 00000001", bus.result); end
        tests_run++; if (bus.id !== 2'd2) begin tests_failed++; $display("FAIL wrap_id2: got %0d want 2", bus.id); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_r [3];
        logic [2:0]  e;
        exp_r[0] = 32'd3;
        exp_r[1] = 32'd6;
        exp_r[2] = 32'd14;
        apply_reset();
        set_op(0, 1'b0, 32'd1, 32'd2);
        set_op(1, 1'b1, 32'd10, 32'd4);
        set_op(2, 1'b0, 32'd7, 32'd7);
        pulse(3'b111);
        for (int k = 0; k < 3; k++) begin
            e = 3'b001 << k;
            tick();
            tests_run++; if (bus.gnt !== e) begin tests_failed++; $display("FAIL b2b_gnt%0d: got %b want %b", k, bus.gnt, e); end
            tick();
            tests_run++; if (bus.valid !== e) begin tests_failed++; $display("FAIL b2b_valid%0d: got %b want %b", k, bus.valid, e); end
            tests_run++; if (bus.result !== exp_r[k]) begin tests_failed++; $display("FAIL b2b_result%0d: got %h want %h", k, bus.result, exp_r[k]); end
        end
        tick();
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle: got %b want 0", bus.busy); end
    endtask

    task automatic test_priority();
        logic [2:0] exp_g [3];
        int         guard;
`ifdef SHARED_ADDER_RR_EN
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b001;
`else
        exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2] = 3'b001;
`endif
        apply_reset();
        pulse(3'b011);
        for (int k = 0; k < 3; k++) begin
            bus.req = 3'b001;
            tick();
            bus.req = 3'b000;
            tests_run++; if (bus.gnt !== exp_g[k]) begin tests_failed++; $display("FAIL prio_gnt%0d: got %b want %b", k, bus.gnt, exp_g[k]); end
            tick();
        end
        guard = 0;
        while (bus.busy === 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL prio_drain: busy got %b want 0 after %0d cycles", bus.busy, guard); end
    endtask

    task automatic test_regrant();
        apply_reset();
        set_op(0, 1'b0, 32'h0000_0005, 32'h0000_0003);
        pulse(3'b001);
        bus.req = 3'b001;
        tick();
        bus.req = 3'b000;
        tests_run++; if (bus.gnt !== 3'b001) begin tests_failed++; $display("FAIL regrant_gnt1: got %b want 001", bus.gnt); end
        tick();
        tests_run++; if (bus.valid !== 3'b001) begin tests_failed++; $display("FAIL regrant_valid1: got %b want 001", bus.valid); end
        tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL regrant_pend: busy got %b want 1", bus.busy); end
        tick();
        tests_run++; if (bus.gnt !== 3'b001) begin tests_failed++; $display("FAIL regrant_gnt2: got %b want 001", bus.gnt); end
        tick();
        tests_run++; if (bus.valid !== 3'b001) begin tests_failed++; $display("FAIL regrant_valid2: got %b want 001", bus.valid); end
        tick();
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL regrant_idle: got %b want 0", bus.busy); end
    endtask

    task automatic test_absorb();
        int n_gnt;
        int n_val;
        apply_reset();
        set_op(1, 1'b0, 32'd1, 32'd1);
        pulse(3'b010);
        bus.req = 3'b001;
        tick();
        tests_run++; if (bus.gnt !== 3'b010) begin tests_failed++; $display("FAIL absorb_gnt1: got %b want 010", bus.gnt); end
        tick();
        bus.req = 3'b000;
        tests_run++; if (bus.valid !== 3'b010) begin tests_failed++; $display("FAIL absorb_valid1: got %b want 010", bus.valid); end
        n_gnt = 0;
        n_val = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.gnt[0] === 1'b1) n_gnt++;
            if (bus.valid[0] === 1'b1) n_val++;
        end
        tests_run++; if (n_gnt != 1) begin tests_failed++; $display("FAIL absorb_gnt_count: got %0d want 1", n_gnt); end
        tests_run++; if (n_val != 1) begin tests_failed++; $display("FAIL absorb_valid_count: got %0d want 1", n_val); end
    endtask

    task automatic test_reset_mid();
        int n_val;
        apply_reset();
        set_op(0, 1'b0, 32'd9, 32'd9);
        pulse(3'b011);
        tick();
        tests_run++; if (bus.gnt !== 3'b001) begin tests_failed++; $display("FAIL rstmid_gnt: got %b want 001", bus.gnt); end
        #1;
        i_rst_n = 1'b0;
        #1;
        tests_run++; if (bus.gnt !== 3'b000) begin tests_failed++; $display("FAIL rstmid_gnt0: got %b want 000", bus.gnt); end
        tests_run++; if (bus.result !== 32'h0) begin tests_failed++; $display("FAIL rstmid_result: got %h want 0", bus.result); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        n_val = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.valid !== 3'b000) n_val++;
        end
        i_rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.valid !== 3'b000) n_val++;
        end
        tests_run++; if (n_val != 0) begin tests_failed++; $display("FAIL rstmid_valid: got %0d pulses want 0", n_val); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_idle: got %b want 0", bus.busy); end
        tests_run++; if (bus.id !== 2'd0) begin tests_failed++; $display("FAIL rstmid_id: got %0d want 0", bus.id); end
    endtask

    initial begin
        bus.req  = 3'b000;
        bus.sub  = 3'b000;
        bus.op_a = '0;
        bus.op_b = '0;
        test_reset();
        test_single();
        test_sub_wrap();
        test_back_to_back();
        test_priority();
        test_regrant();
        test_absorb();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
